// File: rtl/ni_tx_packetizer.sv
// ni_tx_packetizer: NoC network-interface transmit path.
//
// On an accepted start, latches dest/src/len and sends one wormhole packet to
// the local router port. The packet is a head flit followed by len_eff data
// flits, and the last data flit is typed tail. Data word i is read from
// register r<i> through a dedicated register-file read port. That port returns
// data one cycle after the address is presented.
//
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   start        packet request, sampled only while idle
//   dest_id      destination node id, latched on accepted start
//   src_id       this node's id, latched on accepted start
//   len          data word count, latched on accepted start (0 is sent as 1)
//   rf_addr      registered register-file read address
//   rf_rdata     register-file read data, valid the cycle after rf_addr
//   flit_out     registered flit {type[1:0], data}
//   flit_valid   flit_out valid
//   flit_ready   router accepts the flit
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse after the tail flit is accepted
module ni_tx_packetizer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FLIT_W  = 34,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned MAX_LEN = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ID_W-1:0]   dest_id,
    input  logic [ID_W-1:0]   src_id,
    input  logic [2:0]        len,
    output logic [4:0]        rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PadW    = DATA_W - 2 * ID_W - 3;
    localparam logic [2:0]  MaxLen3 = 3'(MAX_LEN);

    localparam logic [1:0] TypeHead = 2'b01;
    localparam logic [1:0] TypeBody = 2'b00;
    localparam logic [1:0] TypeTail = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StRead,
        StWait,
        StSend
    } state_t;

    state_t    state;
    logic [2:0] idx;
    logic [2:0] len_q;
    logic [2:0] len_eff;
    logic       accept;

    // A zero-length request still sends one data word (r1).
    always_comb begin
        len_eff = len;
        if (len == 3'd0) begin
            len_eff = 3'd1;
        end
        if (len > MaxLen3) begin
            len_eff = MaxLen3;
        end
    end

    assign accept = flit_valid && flit_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            idx        <= 3'd0;
            len_q      <= 3'd0;
            rf_addr    <= 5'd0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        len_q      <= len_eff;
                        idx        <= 3'd1;
                        flit_out   <= {TypeHead, dest_id, src_id, len_eff, {PadW{1'b0}}};
                        flit_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= StHead;
                    end
                end
                StHead: begin
                    if (accept) begin
                        flit_valid <= 1'b0;
                        rf_addr    <= {2'b00, idx};
                        state      <= StRead;
                    end
                end
                // Address is on the port this cycle; data returns next cycle.
                StRead: begin
                    state <= StWait;
                end
                // Capture the word once. Later register writes do not affect the held flit.
                StWait: begin
                    flit_out   <= {(idx == len_q) ? TypeTail : TypeBody, rf_rdata};
                    flit_valid <= 1'b1;
                    state      <= StSend;
                end
                StSend: begin
                    if (accept) begin
                        flit_valid <= 1'b0;
                        if (idx == len_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            idx     <= idx + 3'd1;
                            rf_addr <= {2'b00, idx + 3'd1};
                            state   <= StRead;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
